// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } irq_state_t;

    localparam logic [15:0] DEF_ACK_ADDR  = 16'h0022;
    localparam logic [15:0] DEF_MASK_ADDR = 16'h0023;
    localparam logic [15:0] DEF_PEND_ADDR = 16'h0024;
    localparam logic [15:0] DEF_STAT_ADDR = 16'h0025;

    localparam logic [2:0] VEC_TIMER = 3'd1;
    localparam logic [2:0] VEC_KEYB  = 3'd2;
    localparam logic [2:0] VEC_SPI   = 3'd3;

    localparam int STAT_BUSY_BIT = 7;
    localparam int STAT_TOUT_BIT = 6;
    localparam int STAT_VECT_LSB = 0;

endpackage

// File: rtl/irq_prio.sv
// rtl/irq_prio.sv - lowest-index-wins priority encoder over vectors 7..1
module irq_prio (
    input  logic [7:1] eligible_i,
    output logic       valid_o,
    output logic [2:0] index_o
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        index_o = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (eligible_i[i]) begin
                valid_o = 1'b1;
                index_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - pending/mask latch and toggle-style dispatch to the AVR core
module irq_ctl
    import irq_pkg::*;
#(
    parameter logic [15:0] ACK_ADDR    = DEF_ACK_ADDR,
    parameter logic [15:0] MASK_ADDR   = DEF_MASK_ADDR,
    parameter logic [15:0] PEND_ADDR   = DEF_PEND_ADDR,
    parameter logic [15:0] STAT_ADDR   = DEF_STAT_ADDR,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  src,
    input  logic [15:0] address,
    input  logic [7:0]  data_o,
    input  logic        we,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        intr,
    output logic [2:0]  vect,
    output logic        busy
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

    irq_state_t    state_q;
    logic          intr_q;
    logic [2:0]    vect_q;
    logic [7:0]    pending_q, pending_d;
    logic [7:0]    mask_q, mask_d;
    logic          tout_q;
    logic [CW-1:0] cnt_q;

    logic [7:1] eligible;
    logic       win_valid;
    logic [2:0] win_idx;
    logic       dispatch;
    logic       ack_wr, mask_wr, pend_wr, stat_wr;
    logic       expire;
    logic [7:0] clr;
    logic [7:0] stat;

    assign eligible = pending_q[7:1] & mask_q[7:1];

    irq_prio u_prio (
        .eligible_i (eligible),
        .valid_o    (win_valid),
        .index_o    (win_idx)
    );

    assign ack_wr   = we && (address == ACK_ADDR);
    assign mask_wr  = we && (address == MASK_ADDR);
    assign pend_wr  = we && (address == PEND_ADDR);
    assign stat_wr  = we && (address == STAT_ADDR);
    assign dispatch = (state_q == IDLE) && win_valid;
    assign expire   = (ACK_TIMEOUT != 0) && (state_q == WAIT) && (cnt_q == CNT_LAST);

    // A fresh src pulse overrides any clear in the same cycle so no event is lost.
    always_comb begin
        clr = pend_wr ? data_o : 8'h00;
        if (dispatch) begin
            clr[win_idx] = 1'b1;
        end
        pending_d = ((pending_q & ~clr) | src) & 8'hFE;
        mask_d    = mask_wr ? data_o : mask_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            intr_q    <= 1'b0;
            vect_q    <= 3'd0;
            pending_q <= 8'h00;
            mask_q    <= 8'hFF;
            tout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            if (stat_wr) begin
                tout_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        vect_q  <= win_idx;
                        intr_q  <= ~intr_q;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_wr) begin
                        state_q <= IDLE;
                    end else if (expire) begin
                        tout_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stat                            = 8'h00;
        stat[STAT_BUSY_BIT]             = busy;
        stat[STAT_TOUT_BIT]             = tout_q;
        stat[STAT_VECT_LSB +: 3]        = vect_q;
    end

    always_comb begin
        rd_data = 8'h00;
        if (address == MASK_ADDR) begin
            rd_data = mask_q;
        end else if (address == PEND_ADDR) begin
            rd_data = pending_q;
        end else if (address == STAT_ADDR) begin
            rd_data = stat;
        end
    end

    assign rd_hit = (address == MASK_ADDR) || (address == PEND_ADDR) || (address == STAT_ADDR);
    assign intr   = intr_q;
    assign vect   = vect_q;
    assign busy   = (state_q == WAIT);

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - scoreboard bench for irq_ctl
module tb_irq_ctl;
    import irq_pkg::*;

    localparam logic [15:0] A_ACK  = 16'h0022;
    localparam logic [15:0] A_MASK = 16'h0023;
    localparam logic [15:0] A_PEND = 16'h0024;
    localparam logic [15:0] A_STAT = 16'h0025;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  src = 8'h00;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_o = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic        intr;
    logic [2:0]  vect;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic exp_intr = 1'b0;
    logic intr_prev = 1'b0;
    logic [2:0] sb_q[$];

    irq_ctl #(.ACK_TIMEOUT(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .src     (src),
        .address (address),
        .data_o  (data_o),
        .we      (we),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .intr    (intr),
        .vect    (vect),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Every intr toggle consumes one expected vector from the scoreboard.
    always @(negedge clock) begin
        if (reset_n && (intr !== intr_prev)) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got vect %0d expected no dispatch", vect);
            end else begin
                logic [2:0] e;
                e = sb_q.pop_front();
                if (vect !== e) $display("FAIL sb_vect: got %0d expected %0d", vect, e);
                else pass_cnt++;
            end
        end
        intr_prev = intr;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a; data_o = d; we = 1'b1;
        tick();
        we = 1'b0; address = 16'h0000; data_o = 8'h00;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = rd_data;
        address = 16'h0000;
    endtask

    task automatic pulse_src(input logic [7:0] v);
        src = v;
        tick();
        src = 8'h00;
    endtask

    task automatic dispatch_expect(input logic [2:0] v);
        sb_q.push_back(v);
        exp_intr = ~exp_intr;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        total_cnt++; if (intr !== 1'b0) $display("FAIL rst_intr: got %b expected 0", intr); else pass_cnt++;
        total_cnt++; if (vect !== 3'd0) $display("FAIL rst_vect: got %0d expected 0", vect); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
        rd(A_MASK, d);
        total_cnt++; if (d !== 8'hFF) $display("FAIL rst_mask: got %h expected ff", d); else pass_cnt++;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h00) $display("FAIL rst_pend: got %h expected 00", d); else pass_cnt++;
        rd(A_STAT, d);
        total_cnt++; if (d !== 8'h00) $display("FAIL rst_stat: got %h expected 00", d); else pass_cnt++;
        address = A_STAT; #1;
        total_cnt++; if (rd_hit !== 1'b1) $display("FAIL rd_hit_stat: got %b expected 1", rd_hit); else pass_cnt++;
        address = A_ACK; #1;
        total_cnt++; if (rd_hit !== 1'b0 || rd_data !== 8'h00)
            $display("FAIL rd_hit_ack: got hit %b data %h expected 0 00", rd_hit, rd_data); else pass_cnt++;
        address = 16'h0000;
    endtask

    task automatic test_single();
        logic [7:0] d;
        pulse_src(8'h04);
        total_cnt++; if (intr !== exp_intr) $display("FAIL single_early: got intr %b expected %b", intr, exp_intr); else pass_cnt++;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h04) $display("FAIL single_pend_set: got %h expected 04", d); else pass_cnt++;
        dispatch_expect(VEC_KEYB);
        tick();
        total_cnt++; if (intr !== exp_intr || vect !== VEC_KEYB)
            $display("FAIL single_dispatch: got intr %b vect %0d expected %b 2", intr, vect, exp_intr); else pass_cnt++;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h00) $display("FAIL single_pend_clr: got %h expected 00", d); else pass_cnt++;
        rd(A_STAT, d);
        total_cnt++; if (d !== 8'h82) $display("FAIL single_stat: got %h expected 82", d); else pass_cnt++;
        wr(A_ACK, 8'h5A);
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_ack: got busy %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_two_sources();
        logic [7:0] d;
        pulse_src(8'h06);
        dispatch_expect(VEC_TIMER);
        tick();
        total_cnt++; if (intr !== exp_intr || vect !== VEC_TIMER)
            $display("FAIL two_first: got intr %b vect %0d expected %b 1", intr, vect, exp_intr); else pass_cnt++;
        tick();
        total_cnt++; if (intr !== exp_intr || busy !== 1'b1)
            $display("FAIL two_no_preempt: got intr %b busy %b expected %b 1", intr, busy, exp_intr); else pass_cnt++;
        wr(A_ACK, 8'h00);
        dispatch_expect(VEC_KEYB);
        tick();
        total_cnt++; if (intr !== exp_intr || vect !== VEC_KEYB)
            $display("FAIL two_second: got intr %b vect %0d expected %b 2", intr, vect, exp_intr); else pass_cnt++;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h00) $display("FAIL two_pend: got %h expected 00", d); else pass_cnt++;
        wr(A_ACK, 8'h00);
    endtask

    task automatic test_mask();
        logic [7:0] d;
        wr(A_MASK, 8'hFB);
        pulse_src(8'h04);
        tick(); tick();
        total_cnt++; if (intr !== exp_intr || busy !== 1'b0)
            $display("FAIL mask_hold: got intr %b busy %b expected %b 0", intr, busy, exp_intr); else pass_cnt++;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h04) $display("FAIL mask_pend: got %h expected 04", d); else pass_cnt++;
        rd(A_MASK, d);
        total_cnt++; if (d !== 8'hFB) $display("FAIL mask_read: got %h expected fb", d); else pass_cnt++;
        wr(A_ACK, 8'h00);
        total_cnt++; if (busy !== 1'b0 || intr !== exp_intr)
            $display("FAIL ack_idle: got busy %b intr %b expected 0 %b", busy, intr, exp_intr); else pass_cnt++;
        wr(A_MASK, 8'hFF);
        total_cnt++; if (intr !== exp_intr) $display("FAIL unmask_early: got intr %b expected %b", intr, exp_intr); else pass_cnt++;
        dispatch_expect(VEC_KEYB);
        tick();
        total_cnt++; if (intr !== exp_intr || vect !== VEC_KEYB)
            $display("FAIL unmask_dispatch: got intr %b vect %0d expected %b 2", intr, vect, exp_intr); else pass_cnt++;
        wr(A_ACK, 8'h00);
        wr(A_MASK, 8'hFB);
        pulse_src(8'h04);
        wr(A_PEND, 8'h04);
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h00) $display("FAIL w1c_clear: got %h expected 00", d); else pass_cnt++;
        wr(A_MASK, 8'hFF);
        tick(); tick();
        total_cnt++; if (intr !== exp_intr || busy !== 1'b0)
            $display("FAIL w1c_no_dispatch: got intr %b busy %b expected %b 0", intr, busy, exp_intr); else pass_cnt++;
    endtask

    task automatic test_w1c_race();
        logic [7:0] d;
        pulse_src(8'h02);
        dispatch_expect(VEC_TIMER);
        tick();
        src = 8'h04; address = A_PEND; data_o = 8'h04; we = 1'b1;
        tick();
        src = 8'h00; address = 16'h0000; data_o = 8'h00; we = 1'b0;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h04) $display("FAIL race_set_wins: got %h expected 04", d); else pass_cnt++;
        wr(A_ACK, 8'h00);
        dispatch_expect(VEC_KEYB);
        tick();
        total_cnt++; if (intr !== exp_intr || vect !== VEC_KEYB)
            $display("FAIL race_dispatch: got intr %b vect %0d expected %b 2", intr, vect, exp_intr); else pass_cnt++;
        wr(A_ACK, 8'h00);
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        pulse_src(8'h08);
        dispatch_expect(VEC_SPI);
        tick();
        for (int k = 1; k <= 15; k++) tick();
        rd(A_STAT, d);
        total_cnt++; if (busy !== 1'b1 || d !== 8'h83)
            $display("FAIL tout_before: got busy %b stat %h expected 1 83", busy, d); else pass_cnt++;
        tick();
        rd(A_STAT, d);
        total_cnt++; if (busy !== 1'b0 || d !== 8'h43)
            $display("FAIL tout_expire: got busy %b stat %h expected 0 43", busy, d); else pass_cnt++;
        wr(A_STAT, 8'h00);
        rd(A_STAT, d);
        total_cnt++; if (d !== 8'h03) $display("FAIL tout_clear: got %h expected 03", d); else pass_cnt++;
        pulse_src(8'h10);
        dispatch_expect(3'd4);
        tick();
        for (int k = 1; k <= 15; k++) tick();
        wr(A_ACK, 8'h00);
        rd(A_STAT, d);
        total_cnt++; if (busy !== 1'b0 || d !== 8'h04)
            $display("FAIL ack_vs_tout: got busy %b stat %h expected 0 04", busy, d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] v;
        pulse_src(8'h0E);
        dispatch_expect(VEC_TIMER);
        tick();
        for (int i = 0; i < 3; i++) begin
            v = 3'(i + 1);
            total_cnt++; if (busy !== 1'b1 || intr !== exp_intr || vect !== v)
                $display("FAIL b2b_wait%0d: got busy %b intr %b vect %0d expected 1 %b %0d", i, busy, intr, vect, exp_intr, v);
            else pass_cnt++;
            wr(A_ACK, 8'h00);
            total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_ack%0d: got busy %b expected 0", i, busy); else pass_cnt++;
            if (i < 2) begin
                dispatch_expect(3'(i + 2));
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] d;
        pulse_src(8'h02);
        dispatch_expect(VEC_TIMER);
        tick();
        if (exp_intr == 1'b0) begin
            wr(A_ACK, 8'h00);
            pulse_src(8'h02);
            dispatch_expect(VEC_TIMER);
            tick();
        end
        wr(A_MASK, 8'hF0);
        pulse_src(8'h06);
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h06 || intr !== 1'b1 || busy !== 1'b1)
            $display("FAIL pre_reset: got pend %h intr %b busy %b expected 06 1 1", d, intr, busy); else pass_cnt++;
        #1 reset_n = 1'b0;
        exp_intr = 1'b0;
        #1;
        total_cnt++; if (intr !== 1'b0 || vect !== 3'd0 || busy !== 1'b0)
            $display("FAIL async_reset: got intr %b vect %0d busy %b expected 0 0 0", intr, vect, busy); else pass_cnt++;
        rd(A_PEND, d);
        total_cnt++; if (d !== 8'h00) $display("FAIL reset_pend: got %h expected 00", d); else pass_cnt++;
        rd(A_MASK, d);
        total_cnt++; if (d !== 8'hFF) $display("FAIL reset_mask: got %h expected ff", d); else pass_cnt++;
        tick(); tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        total_cnt++; if (intr !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_reset: got intr %b busy %b expected 0 0", intr, busy); else pass_cnt++;
    endtask

    initial begin
        tick(); tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_two_sources();
        test_mask();
        test_w1c_race();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        tick();
        total_cnt++; if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
